// File: rtl/line_fetch_arbiter_if.sv
// Shared-port bus: writer request/grant, frame-memory port and line-buffer write port.
// slave is the arbiter's view; master is the surrounding system's view.
interface line_fetch_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              lb_we;
    logic [8:0]        lb_addr;
    logic [DATA_W-1:0] lb_wdata;

    modport slave (
        input  wr_req, wr_addr, wr_data, mem_rdata,
        output wr_gnt, mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, lb_wdata
    );

    modport master (
        output wr_req, wr_addr, wr_data, mem_rdata,
        input  wr_gnt, mem_en, mem_we, mem_addr, mem_wdata, lb_we, lb_addr, lb_wdata
    );
endinterface

// File: rtl/line_fetch_arbiter.sv
// Prefetches the next display line from frame memory into a ping-pong line buffer
// during horizontal blanking; a writer gets every memory cycle the fetch leaves free.
module line_fetch_arbiter #(
    parameter int FRAME_WIDTH    = 1280,
    parameter int FRAME_HEIGHT   = 1024,
    parameter int H_MAX          = 1688,
    parameter int V_MAX          = 1066,
    parameter int FETCH_START    = 1280,
    parameter int WORDS_PER_LINE = 160,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_h_count,
    input  logic [11:0] i_v_count,
    line_fetch_arbiter_if.slave bus,
    output logic        o_rd_bank,
    output logic        o_busy,
    output logic        o_underrun
);
    localparam int IDX_W = $clog2(FRAME_WIDTH / 8);

    localparam logic [11:0]       L_VLAST    = 12'(V_MAX - 1);
    localparam logic [11:0]       L_HLAST    = 12'(H_MAX - 1);
    localparam logic [11:0]       L_FSTART   = 12'(FETCH_START);
    localparam logic [11:0]       L_FH       = 12'(FRAME_HEIGHT);
    localparam logic [IDX_W-1:0]  L_IDX_LAST = IDX_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] L_WPL      = ADDR_W'(WORDS_PER_LINE);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_line_base;
    logic [IDX_W-1:0]  r_idx;
    logic              r_bank;
    logic              r_underrun;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    // [0]: read on the memory port this cycle, [1]: its data is on mem_rdata now
    logic [1:0]        r_vld_pipe;
    logic [IDX_W:0]    r_p1_tag;
    logic [IDX_W:0]    r_lb_addr;

    logic [11:0]       w_next_line;
    logic              w_trig;
    logic              w_abort;
    logic              w_wr_gnt;

    assign w_next_line = (i_v_count == L_VLAST) ? 12'd0 : i_v_count + 12'd1;
    assign w_trig      = (i_h_count == L_FSTART);
    assign w_abort     = (r_state != IDLE) && (i_h_count == L_HLAST);
    assign w_wr_gnt    = !i_rst && bus.wr_req && (r_state != FETCH);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_line_base <= '0;
            r_idx       <= '0;
            r_bank      <= 1'b0;
            r_underrun  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_vld_pipe  <= '0;
            r_p1_tag    <= '0;
            r_lb_addr   <= '0;
        end else begin
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_vld_pipe <= {r_vld_pipe[0], 1'b0};
            r_lb_addr  <= r_p1_tag;

            if (w_wr_gnt) begin
                r_mem_en    <= 1'b1;
                r_mem_we    <= 1'b1;
                r_mem_addr  <= bus.wr_addr;
                r_mem_wdata <= bus.wr_data;
            end

            case (r_state)
                IDLE: begin
                    if (w_trig) begin
                        r_line_base <= (w_next_line == 12'd0) ? '0 : r_line_base + L_WPL;
                        if (w_next_line < L_FH) begin
                            r_state <= FETCH;
                            r_idx   <= '0;
                            r_bank  <= w_next_line[0];
                        end
                    end
                end
                FETCH: begin
                    if (w_abort) begin
                        r_state    <= IDLE;
                        r_underrun <= 1'b1;
                    end else begin
                        r_mem_en      <= 1'b1;
                        r_mem_we      <= 1'b0;
                        r_mem_addr    <= r_line_base + {{(ADDR_W-IDX_W){1'b0}}, r_idx};
                        r_mem_wdata   <= '0;
                        r_vld_pipe[0] <= 1'b1;
                        r_p1_tag      <= {r_bank, r_idx};
                        r_idx         <= r_idx + 1'b1;
                        if (r_idx == L_IDX_LAST)
                            r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_abort)
                        r_underrun <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.wr_gnt    = w_wr_gnt;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.lb_we     = r_vld_pipe[1];
    assign bus.lb_addr   = r_lb_addr;
    // Memory data is only valid in the strobe cycle; hold the bus at zero otherwise.
    assign bus.lb_wdata  = r_vld_pipe[1] ? bus.mem_rdata : '0;

    assign o_rd_bank  = !i_rst && i_v_count[0];
    assign o_busy     = (r_state != IDLE);
    assign o_underrun = r_underrun;
endmodule
